dmem_port: RTL and testbench
============================

# dmem_port

Data-memory responder for the RV64I pipeline. It accepts one load/store request per cycle from the MEM1 stage and returns load data one cycle later in MEM2, where MEM2MEM3 captures it as `wMemRead`. It holds a synchronous byte-enabled RAM, performs RV64I size/sign extraction, flags misaligned accesses, and forwards byte stores to a memory-mapped TX port through a ready/valid handshake that stalls the pipeline.

## Interface
Parameters:
- `DATA_WIDTH`, 64, data and address width (from `pipeline_pkg`).
- `DEPTH`, 4096, RAM depth in 64-bit words; must be a power of two.
- `MMIO_TX_ADDR`, 64'h1000_0000, byte address of the TX register.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  MEM1 request valid (the MEM1 `enable` bit).
- `req_ren`  in  1  load.
- `req_wen`  in  1  store; `req_ren` and `req_wen` are never both 1.
- `req_size`  in  3  RISC-V funct3 (`mem_size_e`).
- `req_addr`  in  DATA_WIDTH  byte address (MEM1 `ALU_Result`).
- `req_wdata`  in  DATA_WIDTH  store data, right-aligned.
- `pipe_stall`  in  1  external stall from the hazard unit.
- `rsp_rdata`  out  DATA_WIDTH  extended load data, valid in MEM2.
- `rsp_valid`  out  1  `rsp_rdata` belongs to an accepted load.
- `rsp_misalign`  out  1  the accepted request was misaligned.
- `stall_req`  out  1  pipeline must freeze (TX not ready).
- `tx_valid`  out  1  TX byte valid.
- `tx_data`  out  8  TX byte.
- `tx_ready`  in  1  TX sink ready.

## Operation
- A request is accepted when `req_valid & (req_ren|req_wen) & ~pipe_stall & ~stall_req`.
- Size is `req_size[1:0]`: 0 = B, 1 = H, 2 = W, 3 = D. `req_size[2]=1` selects zero-extension (LBU/LHU/LWU). A store with `req_size[2]=1` is illegal and is treated as a no-op.
- Misaligned means `req_addr[size-1:0] != 0`. A misaligned request performs no RAM/TX effect; the next cycle shows `rsp_misalign=1` and `rsp_rdata=0`.
- RAM word index is `req_addr[$clog2(DEPTH)+2:3]`; upper bits are ignored, so addresses wrap modulo DEPTH*8. `MMIO_TX_ADDR` (exact match) is excluded from the RAM.
- Store: byte-enable mask is `((1<<(1<<size))-1) << addr[2:0]`, and data is shifted left by `addr[2:0]*8`. The RAM is written at the accepting edge.
- Load: RAM read is registered at the accepting edge, together with `addr[2:0]`, size, and sign. In the next cycle, combinational logic shifts right by `offset*8`, truncates, and sign- or zero-extends to 64 bits.
- Load from `MMIO_TX_ADDR` returns `{63'b0, tx_ready}`.
- Store (any legal size) to `MMIO_TX_ADDR` sends `req_wdata[7:0]` to `tx_data`.
- FSM:
  - IDLE:
    - Accepted TX store with `tx_ready=1`: pulse `tx_valid` for that cycle (combinational from the request); stay in IDLE.
    - Accepted TX store with `tx_ready=0`: latch the byte and go to TX_WAIT.
  - TX_WAIT:
    - `tx_valid=1` and `stall_req=1`; `tx_data` is held stable.
    - On `tx_valid & tx_ready`, return to IDLE; `stall_req` drops in the same cycle (combinational from `tx_ready`).
- `pipe_stall` or `stall_req` holds `rsp_*` at their current values and does not re-issue the RAM read.

## Timing
- Load latency is 1 cycle: the request is accepted at edge N, and `rsp_rdata` is valid between edges N and N+1, so MEM2MEM3 captures it at N+1.
- A store at edge N followed by a load to the same word accepted at edge N+1 returns the new data; no bypass is needed.
- A non-load accepted cycle drives `rsp_valid=0` and `rsp_rdata=0` in the following cycle.
- Reset values: `rsp_rdata=0`, `rsp_valid=0`, `rsp_misalign=0`, `tx_valid=0`, `tx_data=0`, `stall_req=0`, FSM=IDLE. RAM contents are not reset.
- Asserting `rst_n` low during TX_WAIT drops `tx_valid` and `stall_req` immediately; the pending byte is discarded.
- `tx_ready` may toggle freely; `tx_valid` never deasserts in TX_WAIT without a handshake.

## Structure
- `pipeline_pkg` gains:
  - `mem_size_e` (LB=3'b000 … LWU=3'b110).
  - `MMIO_TX_ADDR` default.
  - `dmem_fsm_e` {IDLE, TX_WAIT}.
- One sub-module, `dmem_ram`: a single-port synchronous RAM with an 8-bit byte-enable and registered read. All extraction, alignment, and FSM logic stays in `dmem_port`.

## Test plan
- SD 0x0123_4567_89AB_CDEF at 0x40, then LD 0x40 -> next cycle `rsp_rdata`=0x0123456789ABCDEF, `rsp_valid`=1.
- SB 0x80 at 0x43, then LB 0x43 -> 0xFFFF_FFFF_FFFF_FF80; LBU 0x43 -> 0x80; LH 0x42 -> 0xFFFF_FFFF_FFFF_80xx (with xx the byte at 0x42).
- LW at 0x42 -> `rsp_misalign`=1, `rsp_rdata`=0. SW at 0x46 -> `rsp_misalign`=1 and a following LD of 0x40 is unchanged.
- SB 0x41 to `MMIO_TX_ADDR` with `tx_ready`=0 for 3 cycles -> `stall_req`=1 for 3 cycles, `tx_data`=0x41 stable; released in the cycle `tx_ready`=1.
- `rst_n` low during TX_WAIT -> `tx_valid`, `stall_req`, and `rsp_*` go to 0 without a clock edge; FSM=IDLE after release.
- Load accepted, then `pipe_stall`=1 for 2 cycles with a new request present -> `rsp_rdata` held and the new request is ignored until the stall drops.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared RV64I pipeline types: memory access sizes, data-memory FSM states and MMIO defaults.
package pipeline_pkg;

    localparam int unsigned DATA_WIDTH = 64;
    localparam logic [63:0] MMIO_TX_ADDR_DEFAULT = 64'h1000_0000;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LD  = 3'b011,
        LBU = 3'b100,
        LHU = 3'b101,
        LWU = 3'b110
    } mem_size_e;

    typedef enum logic {
        IDLE    = 1'b0,
        TX_WAIT = 1'b1
    } dmem_fsm_e;

    // Unshifted byte-enable pattern for an access of 1, 2, 4 or 8 bytes.
    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, 64-bit words, per-byte write enable, registered read.
module dmem_ram #(
    parameter int unsigned DEPTH = 4096,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [7:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [63:0] mem_q [DEPTH];
    logic [63:0] rdata_q;

    // Read data only updates on a read access, so stalls keep the last word.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < 8; b++) begin
                    if (be[b]) begin
                        mem_q[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_port.sv
// MEM1/MEM2 data-memory responder: byte-enabled RAM, RV64I load extraction,
// misalignment flagging and a stalling memory-mapped TX byte port.
module dmem_port
    import pipeline_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH   = pipeline_pkg::DATA_WIDTH,
    parameter int unsigned            DEPTH        = 4096,
    parameter logic [DATA_WIDTH-1:0]  MMIO_TX_ADDR = DATA_WIDTH'(MMIO_TX_ADDR_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_ren,
    input  logic                  req_wen,
    input  logic [2:0]            req_size,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  pipe_stall,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_valid,
    output logic                  rsp_misalign,
    output logic                  stall_req,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    input  logic                  tx_ready
);

    localparam int unsigned AW = $clog2(DEPTH);

    dmem_fsm_e state_q, state_d;
    logic [7:0] tx_byte_q, tx_byte_d;

    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_mis_q, rsp_mis_d;
    logic       rsp_mmio_q, rsp_mmio_d;
    logic       mmio_bit_q, mmio_bit_d;
    logic [2:0] off_q, off_d;
    logic [1:0] size_q, size_d;
    logic       zext_q, zext_d;

    logic                  hold_c, accept_c, misalign_c, is_mmio_c;
    logic                  good_c, st_ok_c, tx_st_c, ram_en_c;
    logic [7:0]            be_c;
    logic [DATA_WIDTH-1:0] wdata_sh_c, ram_rdata, sh_c, ext_c;

    assign stall_req = (state_q == TX_WAIT) & ~tx_ready;
    assign hold_c    = pipe_stall | stall_req;
    assign accept_c  = req_valid & (req_ren | req_wen) & ~hold_c;
    assign is_mmio_c = (req_addr == MMIO_TX_ADDR);

    always_comb begin
        misalign_c = 1'b0;
        case (req_size[1:0])
            2'd0:    misalign_c = 1'b0;
            2'd1:    misalign_c = req_addr[0];
            2'd2:    misalign_c = |req_addr[1:0];
            default: misalign_c = |req_addr[2:0];
        endcase
    end

    // Stores with the zero-extend bit set are illegal and dropped.
    assign good_c     = accept_c & ~misalign_c;
    assign st_ok_c    = good_c & req_wen & ~req_size[2];
    assign tx_st_c    = st_ok_c & is_mmio_c;
    assign ram_en_c   = ~is_mmio_c & ((good_c & req_ren) | st_ok_c);
    assign be_c       = size_mask(req_size[1:0]) << req_addr[2:0];
    assign wdata_sh_c = req_wdata << {req_addr[2:0], 3'b000};

    dmem_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .en    (ram_en_c),
        .we    (req_wen),
        .be    (be_c),
        .addr  (req_addr[AW+2:3]),
        .wdata (wdata_sh_c),
        .rdata (ram_rdata)
    );

    // TX handshake; a new TX store in the handshake cycle refills the holding byte.
    always_comb begin
        state_d   = state_q;
        tx_byte_d = tx_byte_q;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        case (state_q)
            IDLE: begin
                if (tx_st_c) begin
                    if (tx_ready) begin
                        tx_valid = 1'b1;
                        tx_data  = req_wdata[7:0];
                    end else begin
                        state_d   = TX_WAIT;
                        tx_byte_d = req_wdata[7:0];
                    end
                end
            end
            TX_WAIT: begin
                tx_valid = 1'b1;
                tx_data  = tx_byte_q;
                if (tx_ready) begin
                    if (tx_st_c) begin
                        tx_byte_d = req_wdata[7:0];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_mis_d   = rsp_mis_q;
        rsp_mmio_d  = rsp_mmio_q;
        mmio_bit_d  = mmio_bit_q;
        off_d       = off_q;
        size_d      = size_q;
        zext_d      = zext_q;
        if (!hold_c) begin
            rsp_valid_d = accept_c & req_ren;
            rsp_mis_d   = accept_c & misalign_c;
            rsp_mmio_d  = accept_c & req_ren & is_mmio_c;
            mmio_bit_d  = tx_ready;
            off_d       = req_addr[2:0];
            size_d      = req_size[1:0];
            zext_d      = req_size[2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tx_byte_q   <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_mis_q   <= 1'b0;
            rsp_mmio_q  <= 1'b0;
            mmio_bit_q  <= 1'b0;
            off_q       <= 3'd0;
            size_q      <= 2'd0;
            zext_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_byte_q   <= tx_byte_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_mis_q   <= rsp_mis_d;
            rsp_mmio_q  <= rsp_mmio_d;
            mmio_bit_q  <= mmio_bit_d;
            off_q       <= off_d;
            size_q      <= size_d;
            zext_q      <= zext_d;
        end
    end

    // MEM2 extraction from the registered RAM word.
    assign sh_c = ram_rdata >> {off_q, 3'b000};

    always_comb begin
        ext_c = '0;
        case (size_q)
            2'd0:    ext_c = zext_q ? {56'b0, sh_c[7:0]}  : {{56{sh_c[7]}},  sh_c[7:0]};
            2'd1:    ext_c = zext_q ? {48'b0, sh_c[15:0]} : {{48{sh_c[15]}}, sh_c[15:0]};
            2'd2:    ext_c = zext_q ? {32'b0, sh_c[31:0]} : {{32{sh_c[31]}}, sh_c[31:0]};
            default: ext_c = sh_c;
        endcase
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_misalign = rsp_mis_q;
    assign rsp_rdata    = (!rsp_valid_q || rsp_mis_q) ? '0 :
                          rsp_mmio_q ? {{(DATA_WIDTH-1){1'b0}}, mmio_bit_q} : ext_c;

endmodule

// File: tb/tb_dmem_port.sv
// Randomized scoreboard bench for dmem_port against a byte-array reference model.
module tb_dmem_port;
    import pipeline_pkg::*;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned NBYTES = DEPTH * 8;
    localparam logic [63:0] TXA = 64'h1000_0000;

    logic        clk, rst_n;
    logic        req_valid, req_ren, req_wen, pipe_stall, tx_ready;
    logic [2:0]  req_size;
    logic [63:0] req_addr, req_wdata, rsp_rdata;
    logic        rsp_valid, rsp_misalign, stall_req, tx_valid;
    logic [7:0]  tx_data;

    dmem_port #(.DATA_WIDTH(64), .DEPTH(DEPTH), .MMIO_TX_ADDR(TXA)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ren(req_ren),
        .req_wen(req_wen), .req_size(req_size), .req_addr(req_addr),
        .req_wdata(req_wdata), .pipe_stall(pipe_stall), .rsp_rdata(rsp_rdata),
        .rsp_valid(rsp_valid), .rsp_misalign(rsp_misalign), .stall_req(stall_req),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic        m;
        logic [63:0] d;
        logic        st;
        logic        tv;
        logic [7:0]  td;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_fail = 0;

    logic [7:0]  mb [NBYTES];
    logic        e_v, e_m;
    logic [63:0] e_d;
    bit          pend;
    logic [7:0]  pbyte;

    function automatic int bidx(input logic [63:0] a, input int i);
        return int'((a + 64'(i)) % 64'(NBYTES));
    endfunction

    function automatic logic [63:0] load_val(input logic [63:0] a, input logic [2:0] sz);
        int nb = 1 << sz[1:0];
        logic [63:0] r = '0;
        for (int i = 0; i < nb; i++) r = r | (64'(mb[bidx(a, i)]) << (8 * i));
        if (!sz[2] && r[8*nb-1]) r = r | (~64'd0 << (8 * nb));
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // One pipeline cycle: drive, queue expected outputs for this cycle, advance the model.
    task automatic step(input logic v, input logic ren, input logic wen, input logic [2:0] sz,
                        input logic [63:0] a, input logic [63:0] wd,
                        input logic ps, input logic txr);
        bit stall, acc, mis, txst;
        int nb;
        exp_t e;
        req_valid = v; req_ren = ren; req_wen = wen; req_size = sz;
        req_addr = a; req_wdata = wd; pipe_stall = ps; tx_ready = txr;
        nb    = 1 << sz[1:0];
        stall = pend && !txr;
        acc   = v && (ren || wen) && !ps && !stall;
        mis   = (a % 64'(nb)) != 0;
        txst  = acc && wen && !sz[2] && !mis && (a == TXA);
        e.v  = e_v;
        e.m  = e_m;
        e.d  = e_d;
        e.st = stall;
        e.tv = pend || (txst && txr);
        e.td = pend ? pbyte : ((txst && txr) ? wd[7:0] : 8'h00);
        q.push_back(e);
        @(posedge clk);
        #1;
        if (pend) begin
            if (txr) begin
                pend  = txst;
                pbyte = wd[7:0];
            end
        end else if (txst && !txr) begin
            pend  = 1'b1;
            pbyte = wd[7:0];
        end
        if (!(ps || stall)) begin
            e_v = acc && ren;
            e_m = acc && mis;
            e_d = '0;
            if (acc && !mis) begin
                if (ren) begin
                    e_d = (a == TXA) ? 64'(txr) : load_val(a, sz);
                end else if (!sz[2] && a != TXA) begin
                    for (int i = 0; i < nb; i++) mb[bidx(a, i)] = wd[8*i +: 8];
                end
            end
        end
    endtask

    task automatic idle(input logic txr);
        step(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0, txr);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && q.size() > 0) begin
            e = q.pop_front();
            n_chk++;
            if ({rsp_valid, rsp_misalign, rsp_rdata, stall_req, tx_valid, tx_data} !== e) begin
                n_fail++;
                $display("FAIL cycle_out: got v=%0b m=%0b d=%h stall=%0b txv=%0b txd=%h expected v=%0b m=%0b d=%h stall=%0b txv=%0b txd=%h",
                         rsp_valid, rsp_misalign, rsp_rdata, stall_req, tx_valid, tx_data,
                         e.v, e.m, e.d, e.st, e.tv, e.td);
            end
        end
    end

    task automatic reset_model();
        e_v = 1'b0; e_m = 1'b0; e_d = '0; pend = 1'b0; pbyte = 8'h00;
    endtask

    initial begin
        logic [63:0] a, wd;
        logic [2:0]  sz;
        int          op;
        rst_n = 1'b0; req_valid = 1'b0; req_ren = 1'b0; req_wen = 1'b0; req_size = 3'd0;
        req_addr = '0; req_wdata = '0; pipe_stall = 1'b0; tx_ready = 1'b1;
        reset_model();
        #3;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_misalign", 64'(rsp_misalign), 64'd0);
        chk("reset_rsp_rdata", rsp_rdata, 64'd0);
        chk("reset_tx", {55'd0, tx_valid, tx_data}, 64'd0);
        chk("reset_stall_req", 64'(stall_req), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        for (int w = 0; w < int'(DEPTH); w++)
            step(1'b1, 1'b0, 1'b1, LD, 64'(w * 8), {$urandom, $urandom}, 1'b0, 1'b1);

        step(1'b1, 1'b0, 1'b1, LD, 64'h40, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, LD, 64'h40, 64'd0, 1'b0, 1'b1);
        idle(1'b1);
        chk("ld_0x40_model", e_d, 64'd0);
        step(1'b1, 1'b0, 1'b1, LB, 64'h43, 64'h80, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, LB, 64'h43, 64'd0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, LBU, 64'h43, 64'd0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, LH, 64'h42, 64'd0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, LW, 64'h42, 64'd0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, LW, 64'h46, 64'hDEAD_BEEF, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, LD, 64'h40, 64'd0, 1'b0, 1'b1);

        step(1'b1, 1'b0, 1'b1, LB, TXA, 64'h41, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b1, 1'b0, LD, 64'h48, 64'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, LD, 64'h48, 64'd0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, LD, TXA, 64'd0, 1'b0, 1'b1);

        step(1'b1, 1'b0, 1'b1, LB, TXA, 64'h5A, 1'b0, 1'b0);
        idle(1'b0);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_in_txwait_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_in_txwait_stall_req", 64'(stall_req), 64'd0);
        chk("rst_in_txwait_rsp", {62'd0, rsp_valid, rsp_misalign}, 64'd0);
        chk("rst_in_txwait_rdata", rsp_rdata, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        reset_model();
        step(1'b1, 1'b0, 1'b1, LB, TXA, 64'h33, 1'b0, 1'b1);

        step(1'b1, 1'b1, 1'b0, LD, 64'h48, 64'd0, 1'b0, 1'b1);
        repeat (2) step(1'b1, 1'b1, 1'b0, LW, 64'h50, 64'd0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, LW, 64'h50, 64'd0, 1'b0, 1'b1);

        for (int n = 0; n < 600; n++) begin
            op = int'($urandom_range(0, 9));
            sz = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 4) == 0) a = TXA;
            else a = 64'($urandom_range(0, NBYTES - 1)) + 64'(NBYTES * $urandom_range(0, 3));
            if (op < 7 && a != TXA && $urandom_range(0, 1) == 1) a = a & ~64'((1 << sz[1:0]) - 1);
            wd = {$urandom, $urandom};
            step(op < 9, op < 4, op >= 4 && op < 9, sz, a, wd,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
        end
        repeat (3) idle(1'b1);
        @(negedge clk); #1;
        chk("scoreboard_drained", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
